jtdd_objdma: RTL and testbench

JTDD_OBJDMA -- requirements
Module: jtdd_objdma

---
 rtl/jtdd_pkg.sv | 15 +
 rtl/jtdd_objdma_if.sv | 21 ++
 rtl/jtdd_objdma.sv | 150 +++++++++++++++
 tb/tb_jtdd_objdma.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_pkg.sv
// Shared constants for the object-RAM to sprite-table DMA: FSM encoding,
// object table length and bus-grant timeout.
package jtdd_pkg;
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ   = 3'd1;
  localparam state_t ST_COPY  = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_REL   = 3'd4;

  localparam int         OBJ_LEN  = 512;
  localparam logic [7:0] TIMEOUT  = 8'd255;
  localparam logic [8:0] LAST_IDX = 9'(OBJ_LEN - 1);
endpackage

// File: rtl/jtdd_objdma_if.sv
// Object-RAM bus and double-buffered sprite-table write port of the DMA.
interface jtdd_objdma_if;
  logic       bus_req;
  logic       bus_ack;
  logic [8:0] obj_AB;
  logic [7:0] ram_dout;
  logic [9:0] buf_addr;
  logic [7:0] buf_din;
  logic       buf_we;
  logic       buf_bank;

  modport master (
    output bus_req, obj_AB, buf_addr, buf_din, buf_we, buf_bank,
    input  bus_ack, ram_dout
  );

  modport slave (
    input  bus_req, obj_AB, buf_addr, buf_din, buf_we, buf_bank,
    output bus_ack, ram_dout
  );
endinterface

// File: rtl/jtdd_objdma.sv
// On each vertical-blank start, borrows the CPU object-RAM bus and copies all
// 512 bytes into the idle half of the sprite table, then flips the bank.
module jtdd_objdma
  import jtdd_pkg::*;
(
  input  logic          clk,
  input  logic          nRESET,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          dma_en,
  jtdd_objdma_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t     st_r;
  logic [8:0] idx_r;
  logic [7:0] cnt_r;
  logic       lvbl_r;
  logic       rd_vld_r;
  logic       last_r;
  logic       ok_r;
  logic       bus_req_r;
  logic [8:0] obj_ab_r;
  logic [9:0] buf_addr_r;
  logic [7:0] buf_din_r;
  logic       buf_we_r;
  logic       buf_bank_r;
  logic       busy_r;
  logic       done_r;
  logic       err_r;

  assign bus.bus_req  = bus_req_r;
  assign bus.obj_AB   = obj_ab_r;
  assign bus.buf_addr = buf_addr_r;
  assign bus.buf_din  = buf_din_r;
  assign bus.buf_we   = buf_we_r;
  assign bus.buf_bank = buf_bank_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;

  // Sprite-table write port: stores the byte addressed on the previous cen.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      buf_we_r   <= 1'b0;
      buf_addr_r <= 10'd0;
      buf_din_r  <= 8'd0;
    end else if (cen) begin
      buf_we_r <= rd_vld_r;
      if (rd_vld_r) begin
        buf_addr_r <= {buf_bank_r, obj_ab_r};
        buf_din_r  <= bus.ram_dout;
      end
    end else begin
      buf_we_r <= 1'b0;
    end
  end

  // Transfer sequencer: trigger, bus arbitration, address issue and release.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      st_r       <= ST_IDLE;
      idx_r      <= 9'd0;
      cnt_r      <= 8'd0;
      lvbl_r     <= 1'b1;
      rd_vld_r   <= 1'b0;
      last_r     <= 1'b0;
      ok_r       <= 1'b0;
      bus_req_r  <= 1'b0;
      obj_ab_r   <= 9'd0;
      buf_bank_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else if (cen) begin
      lvbl_r <= LVBL;
      done_r <= 1'b0;
      case (st_r)
        ST_IDLE: begin
          if (lvbl_r && !LVBL && dma_en) begin
            st_r      <= ST_REQ;
            bus_req_r <= 1'b1;
            busy_r    <= 1'b1;
            cnt_r     <= 8'd0;
            ok_r      <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bus.bus_ack) begin
            st_r     <= ST_COPY;
            obj_ab_r <= 9'd0;
            idx_r    <= 9'd1;
            rd_vld_r <= 1'b1;
            last_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
            if (cnt_r == TIMEOUT - 8'd1) begin
              st_r      <= ST_REL;
              bus_req_r <= 1'b0;
              err_r     <= 1'b1;
            end
          end
        end
        ST_COPY: begin
          // Once the last address has been read, its byte lands on this edge.
          if (last_r) begin
            st_r     <= ST_FLUSH;
            obj_ab_r <= 9'd0;
            rd_vld_r <= 1'b0;
          end else if (bus.bus_ack) begin
            obj_ab_r <= idx_r;
            idx_r    <= idx_r + 9'd1;
            rd_vld_r <= 1'b1;
            last_r   <= (idx_r == LAST_IDX);
          end else begin
            rd_vld_r <= 1'b0;
          end
        end
        ST_FLUSH: begin
          st_r      <= ST_REL;
          bus_req_r <= 1'b0;
          ok_r      <= 1'b1;
          idx_r     <= 9'd0;
          last_r    <= 1'b0;
        end
        ST_REL: begin
          st_r   <= ST_IDLE;
          busy_r <= 1'b0;
          if (ok_r) begin
            buf_bank_r <= ~buf_bank_r;
            done_r     <= 1'b1;
          end
        end
        default: begin
          st_r      <= ST_IDLE;
          bus_req_r <= 1'b0;
          busy_r    <= 1'b0;
          obj_ab_r  <= 9'd0;
          rd_vld_r  <= 1'b0;
          last_r    <= 1'b0;
        end
      endcase
    end else begin
      done_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtdd_objdma.sv
// Directed bench for jtdd_objdma: timeout, full copies, grant drop, retrigger,
// dma_en/cen gating and mid-transfer reset.
module tb_jtdd_objdma;

  logic clk = 1'b0;
  logic nRESET = 1'b0;
  logic cen = 1'b1;
  logic LVBL = 1'b1;
  logic dma_en = 1'b1;
  logic busy, done, err;

  jtdd_objdma_if bif ();

  jtdd_objdma dut (
    .clk    (clk),
    .nRESET (nRESET),
    .cen    (cen),
    .LVBL   (LVBL),
    .dma_en (dma_en),
    .bus    (bif),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [512];
  assign bif.ram_dout = ram[bif.obj_AB];

  int total = 0;
  int bad = 0;
  int wr_total = 0, req_cyc = 0, done_cnt = 0, busy_cyc = 0;
  int hits [1024];
  logic [7:0] wmem [1024];
  int w0, r0, d0, b0;
  int hits0 [1024];
  int mode = 1;
  int ack_seen = 0, ack_left = 0;
  bit ack_dropped = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Bus-grant model: grants 3 cen after request; mode 0 never, mode 2 drops at index 100.
  initial begin
    bif.bus_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!bif.bus_req) begin
        ack_seen = 0; ack_left = 0; ack_dropped = 1'b0; bif.bus_ack = 1'b0;
      end else begin
        ack_seen++;
        if (mode == 0) bif.bus_ack = 1'b0;
        else if (ack_left > 0) begin bif.bus_ack = 1'b0; ack_left--; end
        else if (mode == 2 && !ack_dropped && bif.bus_ack && bif.obj_AB == 9'd100) begin
          bif.bus_ack = 1'b0; ack_dropped = 1'b1; ack_left = 9;
        end else bif.bus_ack = (ack_seen >= 3);
      end
    end
  end

  // Observer of the sprite-table port and status outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (bif.buf_we) begin
        wr_total++;
        hits[bif.buf_addr]++;
        wmem[bif.buf_addr] = bif.buf_din;
      end
      if (bif.bus_req) req_cyc++;
      if (done) done_cnt++;
      if (busy) busy_cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic fill_ram(input logic [7:0] x);
    for (int i = 0; i < 512; i++) ram[i] = 8'(i) ^ x;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic snap();
    w0 = wr_total; r0 = req_cyc; d0 = done_cnt; b0 = busy_cyc;
    hits0 = hits;
  endtask

  task automatic trig();
    @(negedge clk) LVBL = 1'b0;
    repeat (3) @(negedge clk);
    LVBL = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin @(negedge clk); n++; end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_xfer(input string tag, input int bank, input logic [7:0] x, input int exp_req);
    int nb = 0;
    for (int i = 0; i < 512; i++) begin
      int a = bank * 512 + i;
      if (hits[a] - hits0[a] != 1 || wmem[a] !== (8'(i) ^ x)) nb++;
    end
    check({tag, "_writes"}, wr_total - w0, 32'd512);
    check({tag, "_data"}, nb, 32'd0);
    check({tag, "_req_cyc"}, req_cyc - r0, exp_req);
    check({tag, "_done"}, done_cnt - d0, 32'd1);
    check({tag, "_bank"}, {31'd0, bif.buf_bank}, 1 - bank);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bus_req"}, {31'd0, bif.bus_req}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_bank"}, {31'd0, bif.buf_bank}, 32'd0);
    check({tag, "_obj_AB"}, {23'd0, bif.obj_AB}, 32'd0);
    check({tag, "_we"}, {31'd0, bif.buf_we}, 32'd0);
  endtask

  initial begin
    int n;
    int wsnap;
    fill_ram(8'h5A);
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk) nRESET = 1'b1;
    repeat (2) @(negedge clk);

    // grant never arrives
    mode = 0; snap(); trig();
    wait_idle("tmo", 400); settle();
    check("tmo_req_cyc", req_cyc - r0, 32'd255);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_writes", wr_total - w0, 32'd0);
    check("tmo_done", done_cnt - d0, 32'd0);
    check("tmo_bank", {31'd0, bif.buf_bank}, 32'd0);

    // normal transfer into bank 0
    mode = 1; snap(); trig();
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_idle("t1", 2000); settle();
    check_xfer("t1", 0, 8'h5A, 516);
    check("t1_err_sticky", {31'd0, err}, 32'd1);

    // grant dropped for 10 cen at index 100, bank 1
    fill_ram(8'hA5); mode = 2; snap(); trig();
    wait_idle("t2", 2000); settle();
    check_xfer("t2", 1, 8'hA5, 526);
    check("t2_byte100", {24'd0, wmem[612]}, 32'hC1);

    // second vblank during copy is ignored
    fill_ram(8'h3C); mode = 1; snap(); trig();
    n = 0;
    while (bif.obj_AB < 9'd200 && n < 1000) begin @(negedge clk); n++; end
    trig();
    wait_idle("t3", 2000);
    repeat (20) @(negedge clk);
    settle();
    check_xfer("t3", 0, 8'h3C, 516);
    check("t3_no_requeue", {31'd0, busy}, 32'd0);

    // trigger coincident with dma_en fall
    snap();
    @(negedge clk); LVBL = 1'b0; dma_en = 1'b0;
    repeat (3) @(negedge clk); dma_en = 1'b1;
    repeat (3) @(negedge clk); LVBL = 1'b1;
    repeat (5) @(negedge clk); settle();
    check("dmaen_req", req_cyc - r0, 32'd0);
    check("dmaen_busy", busy_cyc - b0, 32'd0);

    // vblank pulse entirely within cen=0 is never seen
    snap();
    @(negedge clk); cen = 1'b0; LVBL = 1'b0;
    repeat (3) @(negedge clk); LVBL = 1'b1;
    repeat (3) @(negedge clk); cen = 1'b1;
    repeat (10) @(negedge clk); settle();
    check("cen_busy", busy_cyc - b0, 32'd0);

    // reset at index 300 aborts, then a new transfer restarts from 0
    fill_ram(8'h5A); mode = 1; snap(); trig();
    n = 0;
    while (bif.obj_AB != 9'd300 && n < 1000) begin @(negedge clk); n++; end
    check("rst_reach", {23'd0, bif.obj_AB}, 32'd300);
    nRESET = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    wsnap = wr_total;
    repeat (4) @(negedge clk);
    #2;
    check("rst_no_writes", wr_total, wsnap);
    @(negedge clk) nRESET = 1'b1;
    repeat (2) @(negedge clk);
    snap(); trig();
    n = 0;
    while (!bif.buf_we && n < 50) begin @(negedge clk); n++; end
    check("rst_first_addr", {22'd0, bif.buf_addr}, 32'd0);
    check("rst_first_din", {24'd0, bif.buf_din}, 32'h5A);
    wait_idle("rst", 2000); settle();
    check_xfer("rst", 0, 8'h5A, 516);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
